// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_pkg
// Description : Shared types and constants for the bit-serial adder
//               controller (state encoding, default operand width).
// Revision    : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

    // Controller states; 2-bit encoding with one spare code.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operand width used when the top is instantiated without override.
    localparam int c_DEFAULT_WIDTH = 4;

endpackage : serial_add_pkg
`default_nettype wire

// File: rtl/serial_add_ctrl_fa_cell.sv
`default_nettype none
// ============================================================================
// Module      : fa_cell
// Description : Purely combinational 1-bit full adder. The serial adder
//               controller time-multiplexes a single instance of it.
// Revision    : 1.0 - initial release
// ============================================================================
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule : fa_cell
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial adder controller. Adds two WIDTH-bit operands plus
//               a carry-in LSB first through one full-adder cell, one bit per
//               clock, with a start/busy/done handshake. Results are held
//               until the next completed operation.
//               Optional feature macro: SERIAL_ADD_OVF_EN adds the registered
//               signed-overflow output ovf.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             c_out,
    output logic             ovf
`else
    output logic             c_out
`endif
);

    localparam int                 c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    // Upper WIDTH-1 bits of the partial-sum shifter. The bit that would sit
    // at position 0 is never observable, so it is not stored; the full
    // WIDTH-bit shifted value is formed in w_s_next.
    logic [WIDTH-2:0]   r_s_sh;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_c_out;

    logic               w_s;
    logic               w_co;
    logic [WIDTH-1:0]   w_s_next;

    // The single shared full-adder cell, fed by the LSBs of the shifters.
    fa_cell u_fa_cell (
        .a  (r_a_sh[0]),
        .b  (r_b_sh[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    assign w_s_next = {w_s, r_s_sh};

    // Sequencer: operand capture, per-bit shifting and result registration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_s_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= c_in;
                        r_s_sh  <= '0;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_s_sh  <= w_s_next[WIDTH-1:1];
                    r_carry <= w_co;
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_cnt   <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_LAST) begin
                        r_sum   <= w_s_next;
                        r_c_out <= w_co;
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic r_ovf;

    // Signed overflow: carry into the MSB differs from the carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (r_state == RUN && r_cnt == c_LAST) begin
            r_ovf <= r_carry ^ w_co;
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy  = (r_state == RUN);
    assign done  = (r_state == DONE);
    assign sum   = r_sum;
    assign c_out = r_c_out;

endmodule : serial_add_ctrl
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Self-checking bench for serial_add_ctrl (WIDTH=4). A
//               transaction-level model predicts busy/done/result every
//               cycle; directed cases pin the model with literal results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

    localparam int W = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         c_in  = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADD_OVF_EN
        .c_out (c_out),
        .ovf   (ovf)
`else
        .c_out (c_out)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_left = number of busy cycles still to come; 0 means free to accept.
    int           m_left = 0;
    bit           m_done = 1'b0;
    logic [W-1:0] m_sum  = '0;
    bit           m_cout = 1'b0;
    bit           m_ovf  = 1'b0;
    logic [W:0]   m_pend = '0;
    bit           m_pend_ovf = 1'b0;

    always @(negedge rst_n) begin
        m_left = 0;
        m_done = 1'b0;
        m_sum  = '0;
        m_cout = 1'b0;
        m_ovf  = 1'b0;
    end

    always @(posedge clk) begin
        logic [W:0] sx;
        cyc++;
        if (rst_n) begin
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_sum  = m_pend[W-1:0];
                    m_cout = m_pend[W];
                    m_ovf  = m_pend_ovf;
                end
            end else if (start) begin
                m_pend     = {1'b0, a} + {1'b0, b} + (W+1)'(c_in);
                sx         = {a[W-1], a} + {b[W-1], b} + (W+1)'(c_in);
                m_pend_ovf = sx[W] ^ sx[W-1];
                m_left     = W;
                m_done     = 1'b0;
            end else begin
                m_done = 1'b0;
            end
        end
        #1;
        chk("busy",  32'(busy),  32'(m_left > 0));
        chk("done",  32'(done),  32'(m_done));
        chk("sum",   32'(sum),   32'(m_sum));
        chk("c_out", 32'(c_out), 32'(m_cout));
`ifdef SERIAL_ADD_OVF_EN
        chk("ovf",   32'(ovf),   32'(m_ovf));
`endif
    end

    // ---------------- directed helpers ----------------
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          input logic [W-1:0] es, input logic ec, input logic eo, input string tag);
        int  nb;
        bit  got;
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_v; c_in = tc;
        @(negedge clk);
        start = 1'b0; a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
        nb  = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (done) got = 1'b1;
            else begin
                if (busy) nb++;
                @(negedge clk);
            end
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_busy_cycles"}, 32'(nb), 32'd4);
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_c_out"}, 32'(c_out), 32'(ec));
`ifdef SERIAL_ADD_OVF_EN
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("unexpected x on ovf expectation");
`endif
        @(negedge clk);
        chk({tag, "_done_single"}, 32'(done), 32'd0);
    endtask

    initial begin
        int nd;
        int d0;
        int d1;
        logic [W-1:0] s_seen;
        logic [W-1:0] s_first;

        // reset state
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum",  32'(sum),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed arithmetic with literal results
        run_op(4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b1, "basic");
        run_op(4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, "carry1");
        run_op(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0, "carry2");
        run_op(4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, "ovf1");
        run_op(4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1, "ovf2");
        run_op(4'b0011, 4'b0001, 1'b0, 4'b0100, 1'b0, 1'b0, "ovf0");

        // start during RUN is ignored
        @(negedge clk);
        start = 1'b1; a = 4'b0010; b = 4'b0011; c_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        nd = 0; s_seen = '0;
        for (int i = 0; i < 10; i++) begin
            if (i == 1) begin start = 1'b1; a = 4'b1111; b = 4'b1111; end
            if (i == 2) start = 1'b0;
            if (done) begin nd++; s_seen = sum; end
            @(negedge clk);
        end
        chk("ign_done_count", 32'(nd), 32'd1);
        chk("ign_sum", 32'(s_seen), 32'b0101);

        // back-to-back with start held high
        @(negedge clk);
        start = 1'b1; a = 4'b0001; b = 4'b0001; c_in = 1'b0;
        @(negedge clk);
        a = 4'b0010; b = 4'b0010;
        nd = 0; d0 = 0; d1 = 0; s_first = '0; s_seen = '0;
        for (int i = 0; i < 15 && nd < 2; i++) begin
            chk("b2b_busy_xor_done", 32'(busy ^ done), 32'd1);
            if (done) begin
                if (nd == 0) begin d0 = i; s_first = sum; end
                else begin d1 = i; s_seen = sum; start = 1'b0; end
                nd++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("b2b_count", 32'(nd), 32'd2);
        chk("b2b_spacing", 32'(d1 - d0), 32'd5);
        chk("b2b_sum1", 32'(s_first), 32'b0010);
        chk("b2b_sum2", 32'(s_seen), 32'b0100);
        @(negedge clk);

        // reset in the 3rd RUN cycle
        @(negedge clk);
        start = 1'b1; a = 4'b0101; b = 4'b0110; c_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_sum",  32'(sum),  32'd0);
        chk("mid_rst_cout", 32'(c_out), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("post_rst_no_done", 32'(nd), 32'd0);
        run_op(4'b0010, 4'b0001, 1'b0, 4'b0011, 1'b0, 1'b0, "post_rst");

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) != 0);
            a     = W'($urandom);
            b     = W'($urandom);
            c_in  = 1'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_serial_add_ctrl
`default_nettype wire

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Sequencing controller that reuses one 1-bit full-adder cell over successive clock cycles to add two WIDTH-bit operands, LSB first. It replaces a WIDTH-stage ripple adder where area matters more than latency, and it presents a start/busy/done handshake to the surrounding logic. Operands are captured on start, and results are held stable until the next accepted start.

## Interface
- WIDTH, 4, operand width in bits; legal range is 2 and above.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to add; sampled on the rising edge of clk.
- a  input  WIDTH  operand A; captured only on an accepted start.
- b  input  WIDTH  operand B; captured only on an accepted start.
- c_in  input  1  carry in; captured only on an accepted start.
- busy  output  1  high while the addition is in progress.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  registered result.
- c_out  output  1  registered carry out.
- ovf  output  1  registered signed overflow; present only with SERIAL_ADD_OVF_EN.

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: one bit processed per cycle.
  - DONE: single cycle, done pulse asserted.
- Accepting a start:
  - start is accepted when the state is IDLE or DONE and start=1 at the clock edge.
  - On accept: a_sh<=a, b_sh<=b, carry<=c_in, s_sh<=0, cnt<=0, state<=RUN.
  - start is ignored while in RUN. Operands are not captured and the operation in progress is unaffected.
- Each RUN cycle:
  - The cell computes s=a_sh[0]^b_sh[0]^carry and co=majority(a_sh[0],b_sh[0],carry).
  - s_sh<={s, s_sh[WIDTH-1:1]}.
  - carry<=co.
  - a_sh and b_sh shift right by 1.
  - cnt<=cnt+1.
- Completion edge (RUN with cnt==WIDTH-1):
  - sum<={s, s_sh[WIDTH-1:1]}, c_out<=co, state<=DONE.
- In DONE:
  - done=1.
  - Next state is RUN if start=1, otherwise IDLE.
- Output behaviour:
  - busy is combinational from state: busy=(state==RUN).
  - done is combinational from state: done=(state==DONE).
  - sum, c_out and ovf change only on the completion edge. They hold their previous result through IDLE and RUN.
- Arithmetic: the result equals a+b+c_in modulo 2^(WIDTH+1), split as {c_out,sum}.
- Counter: cnt is $clog2(WIDTH) bits wide and is never compared beyond WIDTH-1.
- Reset (asynchronous, any state, including mid-RUN):
  - state=IDLE.
  - All shift registers, cnt and carry cleared to 0.
  - sum=0, c_out=0, ovf=0, busy=0, done=0.
  - A partial result is discarded, and no done pulse follows release of reset.

## Timing
- Latency: start is accepted at edge E0, busy=1 from E0 to E_WIDTH, and after E_WIDTH done=1 with the result valid.
  - done rises exactly WIDTH cycles after the accepting edge.
- Throughput: start held high continuously gives one result every WIDTH+1 cycles, because a start in DONE is accepted.
- Input timing: a, b and c_in must be valid only in the accepting cycle.
- Post-reset: the first edge after rst_n deasserts may accept a start.

## Configuration
- SERIAL_ADD_OVF_EN defined:
  - The ovf port exists.
  - On the completion edge, ovf<=carry^co, i.e. the carry into the MSB XOR the carry out of the MSB.
  - ovf resets to 0 and is held like sum.
- SERIAL_ADD_OVF_EN undefined:
  - The ovf port and its flop are absent.
  - All other behaviour is identical.

## Structure
- Package serial_add_pkg:
  - state typedef, enum {IDLE, RUN, DONE}, 2 bits.
  - Default WIDTH constant.
- Sub-module fa_cell:
  - Purely combinational 1-bit full adder: inputs a, b, ci; outputs s, co.
  - Instantiated once.
  - All sequencing lives in serial_add_ctrl.

## Test plan
- Basic add, WIDTH=4: a=0101, b=0011, c_in=0, single start.
  - busy high for 4 cycles, then done pulse with sum=1000 and c_out=0.
- Carry chain: a=1111, b=0001, c_in=0.
  - sum=0000, c_out=1.
  - a=1111, b=1111, c_in=1 gives sum=1111, c_out=1.
- Overflow (SERIAL_ADD_OVF_EN): a=0111, b=0001.
  - sum=1000, ovf=1.
  - a=1000, b=1000 gives sum=0000, c_out=1, ovf=1.
  - a=0011, b=0001 gives ovf=0.
- Ignored start: start=1 in the 2nd RUN cycle with a=1111.
  - Result still matches the first operands.
  - Exactly one done pulse in that window.
- Back-to-back: start held high across two operand pairs (0001+0001, then 0010+0010).
  - done pulses 5 cycles apart with sums 0010 then 0100.
  - busy is low only during the done cycle.
- Reset mid-RUN: assert rst_n=0 in the 3rd RUN cycle.
  - Outputs go to 0 immediately.
  - No done pulse after release.
  - A following start of 0010+0001 yields sum=0011.
